// File: rtl/ext_loader_pkg.sv
// Shared types and constants for the external-memory loader: FSM states,
// address stride shifts and the counter-width helper.
package ext_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoadI,
        StLoadD,
        StRun,
        StDumpReq,
        StDumpCap,
        StDumpOut,
        StDone
    } state_e;

    localparam int unsigned IMEM_STRIDE_SHIFT = 2;
    localparam int unsigned DMEM_STRIDE_SHIFT = 3;

    // Width that holds every index/cycle value up to max(a, b, c) - 1; never below 1 bit.
    function automatic int unsigned cnt_width(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/ext_mem_loader.sv
// Host-side initiator: streams images into imem/dmem, runs the core for a
// fixed cycle budget, then streams dmem back out one word at a time.
module ext_mem_loader
    import ext_loader_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 128,
    parameter int unsigned DMEM_WORDS = 128,
    parameter int unsigned RUN_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy,
    output logic        done,
    output logic        cpu_enable,
    output logic [63:0] imem_addr,
    output logic        imem_wen,
    output logic        imem_ren,
    output logic [31:0] imem_wdata,
    output logic [63:0] dmem_addr,
    output logic        dmem_wen,
    output logic        dmem_ren,
    output logic [63:0] dmem_wdata,
    input  logic [63:0] dmem_rdata
);

    localparam int unsigned CntW = cnt_width(IMEM_WORDS, DMEM_WORDS, RUN_CYCLES);
    localparam logic [CntW-1:0] ImemLast = CntW'(IMEM_WORDS - 1);
    localparam logic [CntW-1:0] DmemLast = CntW'(DMEM_WORDS - 1);
    localparam logic [CntW-1:0] RunLast  = CntW'(RUN_CYCLES - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] idx_q, idx_d;
    logic [CntW-1:0] cyc_q, cyc_d;

    logic [63:0] imem_addr_q, imem_addr_d;
    logic [31:0] imem_wdata_q, imem_wdata_d;
    logic        imem_wen_q, imem_wen_d;
    logic [63:0] dmem_addr_q, dmem_addr_d;
    logic [63:0] dmem_wdata_q, dmem_wdata_d;
    logic        dmem_wen_q, dmem_wen_d;
    logic        dmem_ren_q, dmem_ren_d;
    logic [63:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        cpu_enable_q, cpu_enable_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        in_hs;

    // Decoded straight from the state register so there is no path from in_valid.
    assign in_ready = (state_q == StLoadI) || (state_q == StLoadD);
    assign in_hs    = in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cyc_d        = cyc_q;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        imem_wen_d   = 1'b0;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        dmem_wen_d   = 1'b0;
        dmem_ren_d   = 1'b0;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StLoadI;
                    idx_d   = '0;
                    cyc_d   = '0;
                end
            end
            StLoadI: begin
                if (in_hs) begin
                    imem_wen_d   = 1'b1;
                    imem_addr_d  = 64'(idx_q) << IMEM_STRIDE_SHIFT;
                    imem_wdata_d = in_data[31:0];
                    if (idx_q == ImemLast) begin
                        idx_d   = '0;
                        state_d = StLoadD;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StLoadD: begin
                if (in_hs) begin
                    dmem_wen_d   = 1'b1;
                    dmem_addr_d  = 64'(idx_q) << DMEM_STRIDE_SHIFT;
                    dmem_wdata_d = in_data;
                    if (idx_q == DmemLast) begin
                        idx_d   = '0;
                        state_d = StRun;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StRun: begin
                if (cyc_q == RunLast) begin
                    state_d     = StDumpReq;
                    idx_d       = '0;
                    dmem_ren_d  = 1'b1;
                    dmem_addr_d = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            StDumpReq: state_d = StDumpCap;
            StDumpCap: begin
                out_data_d  = dmem_rdata;
                out_valid_d = 1'b1;
                state_d     = StDumpOut;
            end
            StDumpOut: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (idx_q == DmemLast) begin
                        state_d = StDone;
                    end else begin
                        idx_d       = idx_q + 1'b1;
                        state_d     = StDumpReq;
                        dmem_ren_d  = 1'b1;
                        dmem_addr_d = 64'(idx_d) << DMEM_STRIDE_SHIFT;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Status outputs follow the next state so they line up with it after the edge.
        cpu_enable_d = (state_d == StRun);
        busy_d       = !((state_d == StIdle) || (state_d == StDone));
        done_d       = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            cyc_q        <= '0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            imem_wen_q   <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            dmem_wen_q   <= 1'b0;
            dmem_ren_q   <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            cpu_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cyc_q        <= cyc_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            imem_wen_q   <= imem_wen_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            dmem_wen_q   <= dmem_wen_d;
            dmem_ren_q   <= dmem_ren_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            cpu_enable_q <= cpu_enable_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign imem_wen   = imem_wen_q;
    assign imem_ren   = 1'b0;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign dmem_wen   = dmem_wen_q;
    assign dmem_ren   = dmem_ren_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign cpu_enable = cpu_enable_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_ext_mem_loader.sv
// Scoreboard bench for ext_mem_loader: stimulus queues expected memory
// writes, read addresses and dump words; a negedge monitor pops and compares.
module tb_ext_mem_loader;

    localparam int unsigned IW = 4;
    localparam int unsigned DW = 2;
    localparam int unsigned RC = 8;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, busy, done, cpu_enable;
    logic [63:0] out_data, imem_addr, dmem_addr, dmem_wdata;
    logic        imem_wen, imem_ren, dmem_wen, dmem_ren;
    logic [31:0] imem_wdata;
    logic [63:0] dmem_rdata;

    ext_mem_loader #(
        .IMEM_WORDS(IW),
        .DMEM_WORDS(DW),
        .RUN_CYCLES(RC)
    ) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .cpu_enable(cpu_enable),
        .imem_addr (imem_addr),
        .imem_wen  (imem_wen),
        .imem_ren  (imem_ren),
        .imem_wdata(imem_wdata),
        .dmem_addr (dmem_addr),
        .dmem_wen  (dmem_wen),
        .dmem_ren  (dmem_ren),
        .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    // Data memory model: fixed contents, one-cycle read latency.
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) dmem_rdata <= '0;
        else if (dmem_ren)
            dmem_rdata <= (dmem_addr == 64'd0) ? 64'hAAAA :
                          (dmem_addr == 64'd8) ? 64'hBBBB : 64'hDEAD_BEEF;
    end

    int checks   = 0;
    int failures = 0;

    logic [95:0]  exp_imem[$];
    logic [127:0] exp_dmem[$];
    logic [63:0]  exp_ren[$];
    logic [63:0]  exp_out[$];

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got unexpected event expected none", name);
    endtask

    // Monitor state
    bit          stall_q = 1'b0;
    logic [63:0] stall_data = '0;
    bit          chk_done = 1'b0;
    bit          run_abort = 1'b0;
    bit          cpu_en_prev = 1'b0;
    int          run_len = 0;

    always @(negedge clk) begin
        logic [95:0]  ei;
        logic [127:0] ed;
        logic [63:0]  e64;
        if (chk_done) begin
            check64("done_after_last_out", {63'b0, done}, 64'd1);
            chk_done = 1'b0;
        end
        if (imem_wen) begin
            if (exp_imem.size() == 0) fail_now("imem_wen_unexpected");
            else begin
                ei = exp_imem.pop_front();
                check64("imem_addr", imem_addr, ei[95:32]);
                check64("imem_wdata", {32'b0, imem_wdata}, {32'b0, ei[31:0]});
            end
        end
        if (dmem_wen) begin
            if (exp_dmem.size() == 0) fail_now("dmem_wen_unexpected");
            else begin
                ed = exp_dmem.pop_front();
                check64("dmem_addr_wr", dmem_addr, ed[127:64]);
                check64("dmem_wdata", dmem_wdata, ed[63:0]);
            end
        end
        if (dmem_ren) begin
            check64("ren_wen_exclusive", {63'b0, dmem_wen}, 64'd0);
            if (exp_ren.size() == 0) fail_now("dmem_ren_unexpected");
            else begin
                e64 = exp_ren.pop_front();
                check64("dmem_addr_rd", dmem_addr, e64);
            end
        end
        if (stall_q) begin
            check64("out_valid_held", {63'b0, out_valid}, 64'd1);
            check64("out_data_held", out_data, stall_data);
        end
        if (out_valid && out_ready) begin
            if (exp_out.size() == 0) fail_now("out_unexpected");
            else begin
                e64 = exp_out.pop_front();
                check64("out_data", out_data, e64);
                if (exp_out.size() == 0) chk_done = 1'b1;
            end
        end
        stall_q    = out_valid && !out_ready;
        stall_data = out_data;
        if (cpu_enable) begin
            if (!cpu_en_prev)
                check64("run_starts_with_last_dmem_write", {63'b0, dmem_wen}, 64'd1);
            check64("no_access_in_run", {62'b0, imem_wen, dmem_ren}, 64'd0);
            run_len++;
        end else begin
            if (cpu_en_prev && !run_abort)
                check64("run_length", 64'(run_len), 64'(RC));
            run_len = 0;
        end
        cpu_en_prev = cpu_enable;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check64("in_ready_after_start", {63'b0, in_ready}, 64'd1);
    endtask

    // Sends IW+DW words base+1 .. base+6; imem words carry junk in the ignored upper half.
    task automatic load(input logic [31:0] base, input bit gapped, input bit pulse_start);
        int k = 0;
        int guard = 0;
        logic [31:0] v;
        while (k < int'(IW + DW) && guard < 100) begin
            guard++;
            if (gapped && (guard % 2 == 1)) begin
                in_valid = 1'b0;
                start    = pulse_start && (k == 2);
                tick();
                start = 1'b0;
            end else begin
                v        = base + 32'(k) + 32'd1;
                in_valid = 1'b1;
                check64("in_ready_during_load", {63'b0, in_ready}, 64'd1);
                if (k < int'(IW)) begin
                    in_data = {32'hC0DE_0000 | 32'(k), v};
                    exp_imem.push_back({64'(k * 4), v});
                end else begin
                    in_data = {32'h5A5A_0000 | 32'(k), v};
                    exp_dmem.push_back({64'((k - int'(IW)) * 8), 32'h5A5A_0000 | 32'(k), v});
                end
                k++;
                tick();
            end
        end
        in_valid = 1'b0;
        check64("in_ready_drops_after_load", {63'b0, in_ready}, 64'd0);
    endtask

    task automatic push_dump();
        exp_ren.push_back(64'd0);
        exp_ren.push_back(64'd8);
        exp_out.push_back(64'hAAAA);
        exp_out.push_back(64'hBBBB);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 300) begin
            tick();
            n++;
        end
        check64("done_reached", {63'b0, done}, 64'd1);
        check64("busy_low_in_done", {63'b0, busy}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        // Reset state
        repeat (3) tick();
        check64("reset_outputs_zero",
                {in_ready, out_valid, busy, done, cpu_enable, imem_wen, imem_ren,
                 dmem_wen, dmem_ren} | {9{|{out_data, imem_addr, imem_wdata,
                 dmem_addr, dmem_wdata}}}, 64'd0);
        arst_n = 1'b1;
        tick();

        // Back-to-back load, run window, dump with out_ready held high
        out_ready = 1'b1;
        push_dump();
        do_start();
        check64("busy_in_load", {63'b0, busy}, 64'd1);
        load(32'h10, 1'b0, 1'b0);
        wait_done();

        // Gapped input with ignored start, then backpressure on first dump word
        out_ready = 1'b0;
        push_dump();
        do_start();
        load(32'h20, 1'b1, 1'b1);
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check64("out_valid_seen", {63'b0, out_valid}, 64'd1);
        repeat (5) tick();
        out_ready = 1'b1;
        wait_done();

        // Reset in RUN cycle 3, then restart from imem address 0
        do_start();
        load(32'h30, 1'b0, 1'b0);
        tick();
        tick();
        #2;
        run_abort = 1'b1;
        arst_n    = 1'b0;
        #1;
        check64("cpu_enable_async_drop", {63'b0, cpu_enable}, 64'd0);
        check64("reset_mid_run_zero",
                {55'b0, in_ready, out_valid, busy, done, cpu_enable, imem_wen,
                 dmem_wen, dmem_ren, |{imem_addr, dmem_addr, imem_wdata, dmem_wdata}}, 64'd0);
        tick();
        arst_n = 1'b1;
        tick();
        tick();
        run_abort = 1'b0;
        push_dump();
        do_start();
        load(32'h40, 1'b1, 1'b0);
        wait_done();

        repeat (2) tick();
        check64("imem_queue_drained", 64'(exp_imem.size()), 64'd0);
        check64("dmem_queue_drained", 64'(exp_dmem.size()), 64'd0);
        check64("ren_queue_drained", 64'(exp_ren.size()), 64'd0);
        check64("out_queue_drained", 64'(exp_out.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
